// File: rtl/sync_demux_pkg.sv
// Shared types and constants for the registered 1-to-N demultiplexer.
package sync_demux_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/demux_lane_buf.sv
// Two-entry FIFO for one output lane; slot0 is always the head.
module demux_lane_buf
    import sync_demux_pkg::*;
(
    input  logic  clk,
    input  logic  clr_n,
    input  logic  push,
    input  word_t push_data,
    input  logic  pop,
    output word_t head_data,
    output logic  valid,
    output logic  not_full
);

    logic [1:0] cnt_q, cnt_d;
    word_t      slot0_q, slot0_d;
    word_t      slot1_q, slot1_d;
    logic       do_push, do_pop;

    assign do_pop  = pop && (cnt_q != 2'd0);
    assign do_push = push && (cnt_q != 2'd2);

    always_comb begin
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (cnt_q == 2'd0) slot0_d = push_data;
                else               slot1_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                // Popping to empty leaves slot0 untouched so the lane shows its last word.
                if (cnt_q == 2'd2) slot0_d = slot1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Push and pop together only happens at occupancy 1.
                slot0_d = push_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign head_data = slot0_q;
    assign valid     = (cnt_q != 2'd0);
    assign not_full  = (cnt_q != 2'd2);

endmodule

// File: rtl/sync_demux.sv
// Registered 1-to-NUM_OUT demultiplexer with per-lane 2-deep buffering and
// a saturating counter of words dropped for out-of-range addresses.
module sync_demux
    import sync_demux_pkg::*;
#(
    parameter int NUM_OUT = 2,
    parameter int ADDR_W  = 3
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    logic [NUM_OUT-1:0]    lane_sel;
    logic [NUM_OUT-1:0]    lane_not_full;
    logic                  addr_legal;
    logic                  accept;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
        word_t head;

        assign lane_sel[i] = (in_addr == ADDR_W'(i));

        demux_lane_buf u_buf (
            .clk       (clk),
            .clr_n     (clr_n),
            .push      (accept && lane_sel[i]),
            .push_data (in_data),
            .pop       (out_ready[i]),
            .head_data (head),
            .valid     (out_valid[i]),
            .not_full  (lane_not_full[i])
        );

        assign out_data[i*DATA_W +: DATA_W] = head;
    end

    assign addr_legal = |lane_sel;

    // Illegal addresses are always accepted so a bad producer cannot wedge the input.
    always_comb begin
        in_ready = 1'b1;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (lane_sel[i]) in_ready = lane_not_full[i];
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && !addr_legal && (drop_cnt_q != DROP_CNT_MAX))
            drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;

endmodule
